// File: rtl/crypto_sequencer_pkg.sv
// Shared definitions for the crypto request sequencer: op codes, error codes, FSM states.
// No logic of its own; all latency lives in the sequencer and its timer.
// No flow control here; handshakes are owned by crypto_sequencer.
package crypto_pkg;

  localparam int CRYPTO_W = 16;

  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_OP      = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  // Only encrypt and decrypt are ever forwarded to the core.
  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/crypto_sequencer_pulse_timer.sv
// Loadable down-counter that holds an enable high for exactly load_val cycles.
// Enable rises the cycle after load; 'last' flags the final enabled cycle.
// No backpressure; a new load simply restarts the count.
module seq_pulse_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          active,
  output logic          last
);

  logic [CW-1:0] cnt;

  // Count down to zero after a load; zero means idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign active = (cnt != '0);
  assign last   = (cnt == CW'(1));

endmodule

// File: rtl/crypto_sequencer.sv
// Request-side sequencer: accepts one crypto job, drives core clear/begin, returns the result.
// Latency: clr 1..CLR_CYCLES after accept, then BGN_CYCLES of begin; resp one cycle after last strobe.
// One job in flight; req_ready only in IDLE, response held stable until resp_ready.
module crypto_sequencer
  import crypto_pkg::*;
#(
  parameter int W          = CRYPTO_W,
  parameter int CLR_CYCLES = 2,
  parameter int BGN_CYCLES = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_data,
  input  logic [W-1:0] req_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic [W-1:0] resp_key,
  output logic [1:0]   resp_err,
  output logic         busy,
  output logic         core_clr,
  output logic         core_bgn,
  output logic [1:0]   core_mode,
  output logic [W-1:0] core_data_in,
  output logic [W-1:0] core_key_in,
  input  logic [W-1:0] core_data_out,
  input  logic [W-1:0] core_key_out,
  input  logic         core_data_done,
  input  logic         core_key_done
);

  seq_state_t   state, state_nxt;
  logic [1:0]   lat_op;
  logic [W-1:0] lat_data, lat_key;
  logic         data_seen, key_seen;
  logic [7:0]   tmo_cnt;
  err_t         err_q;

  logic accept, op_ok, run_phase, done_all, tmo_hit;
  logic clr_active, clr_last, bgn_active, bgn_last;

  assign accept    = req_valid && req_ready;
  assign op_ok     = op_legal(req_op);
  assign run_phase = (state == ST_START) || (state == ST_WAIT);
  // Counts a strobe arriving this cycle so resp follows the second strobe by one cycle.
  assign done_all  = (data_seen || core_data_done) && (key_seen || core_key_done);
  assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT));

  seq_pulse_timer #(.CW(4)) u_clr_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && op_ok),
    .load_val (4'(CLR_CYCLES)),
    .active   (clr_active),
    .last     (clr_last)
  );

  seq_pulse_timer #(.CW(4)) u_bgn_timer (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == ST_CLEAR) && clr_last),
    .load_val (4'(BGN_CYCLES)),
    .active   (bgn_active),
    .last     (bgn_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: illegal ops skip the core entirely; completion beats timeout in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)                state_nxt = op_ok ? ST_CLEAR : ST_RESP;
      ST_CLEAR: if (clr_last)              state_nxt = ST_START;
      ST_START: if (bgn_last)              state_nxt = ST_WAIT;
      ST_WAIT:  if (done_all || tmo_hit)   state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready)            state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // Job latches, strobe capture, timeout counter and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_op    <= '0;
      lat_data  <= '0;
      lat_key   <= '0;
      resp_data <= '0;
      resp_key  <= '0;
      data_seen <= 1'b0;
      key_seen  <= 1'b0;
      tmo_cnt   <= '0;
      err_q     <= ERR_OK;
    end else begin
      if (accept) begin
        lat_op    <= req_op;
        lat_data  <= req_data;
        lat_key   <= req_key;
        resp_data <= '0;
        resp_key  <= '0;
        data_seen <= 1'b0;
        key_seen  <= 1'b0;
        err_q     <= op_ok ? ERR_OK : ERR_OP;
      end
      if ((state == ST_CLEAR) && clr_last) begin
        tmo_cnt <= '0;
      end else if (run_phase) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (run_phase && core_data_done) begin
        resp_data <= core_data_out;
        data_seen <= 1'b1;
      end
      if (run_phase && core_key_done) begin
        resp_key <= core_key_out;
        key_seen <= 1'b1;
      end
      if ((state == ST_WAIT) && !done_all && tmo_hit) begin
        err_q <= ERR_TIMEOUT;
      end
      if ((state == ST_RESP) && resp_ready) begin
        data_seen <= 1'b0;
        key_seen  <= 1'b0;
      end
    end
  end

  // Handshake and core-control outputs decoded from state; req_ready held low during reset.
  always_comb begin
    req_ready  = (state == ST_IDLE) && !rst;
    busy       = (state != ST_IDLE);
    resp_valid = (state == ST_RESP);
    core_clr   = (state == ST_CLEAR) && clr_active;
    core_bgn   = (state == ST_START) && bgn_active;
  end

  assign core_mode    = lat_op;
  assign core_data_in = lat_data;
  assign core_key_in  = lat_key;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_crypto_sequencer.sv
module tb_crypto_sequencer;

  localparam int CLR = 2;
  localparam int BGN = 10;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [1:0]  req_op, resp_err, core_mode;
  logic [15:0] req_data, req_key, resp_data, resp_key, core_data_in, core_key_in;
  logic        core_clr, core_bgn;
  logic [15:0] core_data_out  = 16'hEEEE;
  logic [15:0] core_key_out   = 16'h5A5A;
  logic        core_data_done = 1'b0;
  logic        core_key_done  = 1'b0;

  crypto_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_key(resp_key), .resp_err(resp_err), .busy(busy),
    .core_clr(core_clr), .core_bgn(core_bgn), .core_mode(core_mode),
    .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_key_out(core_key_out),
    .core_data_done(core_data_done), .core_key_done(core_key_done)
  );

  always #5 clk = ~clk;

  // Stimulus-owned configuration of the core model and literal pins for the next job.
  int          cfg_dd, cfg_dk;
  bit          cfg_stray;
  bit          pin_on;
  int          pin_rel, pin_clr, pin_bgn, pin_e;
  logic [15:0] pin_d, pin_k;
  bit          end_req;
  int          stim_timeouts;

  // Clock-edge bookkeeping.
  int cyc    = 0;
  bit rst_q  = 1'b0;
  bit chk_en = 1'b0;

  // Model state (written only by the compare process).
  bit          in_job = 1'b0;
  bit          legal;
  int          acc_cyc = 0;
  int          rs, lb, lim, mx;
  logic [1:0]  lat_op = '0, e_err;
  logic [15:0] lat_d = '0, lat_k = '0, e_d, e_k;
  int          last_bgn = -1000;
  int          n_clr, n_bgn;
  bit          rv_seen = 1'b0;
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Cycle counter and core model: strobes a fixed number of cycles after the last core_bgn.
  always @(posedge clk) begin
    bit d_hit, k_hit, stray;
    rst_q = rst;
    if (rst) chk_en = 1'b1;
    cyc = cyc + 1;
    #1;
    d_hit = (cfg_dd >= 0) && (cyc == last_bgn + cfg_dd);
    k_hit = (cfg_dk >= 0) && (cyc == last_bgn + cfg_dk);
    stray = cfg_stray && in_job && (cyc == acc_cyc + 1);
    core_data_done = d_hit || stray;
    core_key_done  = k_hit || stray;
    core_data_out  = d_hit ? 16'hA1B2 : 16'hEEEE;
    core_key_out   = k_hit ? 16'hC3D4 : 16'h5A5A;
  end

  // Compare process: derive every output from the job timeline and check each cycle.
  always @(negedge clk) begin
    int  k;
    bit  e_clr, e_bgn, e_rv;
    if (chk_en) begin
      if (rst_q) begin
        in_job = 1'b0;
        lat_op = '0; lat_d = '0; lat_k = '0;
      end
      k     = cyc - acc_cyc;
      e_clr = in_job && legal && (k >= 1) && (k <= CLR);
      e_bgn = in_job && legal && (k > CLR) && (k <= CLR + BGN);
      e_rv  = in_job && (cyc >= rs);
      chk("req_ready",  32'(req_ready),  32'(!in_job && !rst));
      chk("busy",       32'(busy),       32'(in_job));
      chk("core_clr",   32'(core_clr),   32'(e_clr));
      chk("core_bgn",   32'(core_bgn),   32'(e_bgn));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("core_mode",  32'(core_mode),  32'(lat_op));
      chk("core_data_in", 32'(core_data_in), 32'(lat_d));
      chk("core_key_in",  32'(core_key_in),  32'(lat_k));
      if (e_rv) begin
        chk("resp_data", 32'(resp_data), 32'(e_d));
        chk("resp_key",  32'(resp_key),  32'(e_k));
        chk("resp_err",  32'(resp_err),  32'(e_err));
      end
      if (core_bgn) last_bgn = cyc;
      if (in_job) begin
        if (core_clr) n_clr++;
        if (core_bgn) n_bgn++;
        if (resp_valid && !rv_seen) begin
          rv_seen = 1'b1;
          if (pin_on) begin
            chk("pin latency",   32'(cyc - acc_cyc), 32'(pin_rel));
            chk("pin clr count", 32'(n_clr), 32'(pin_clr));
            chk("pin bgn count", 32'(n_bgn), 32'(pin_bgn));
            chk("pin resp_data", 32'(resp_data), 32'(pin_d));
            chk("pin resp_key",  32'(resp_key),  32'(pin_k));
            chk("pin resp_err",  32'(resp_err),  32'(pin_e));
          end
        end
      end
      if (in_job && e_rv && resp_ready) begin
        in_job = 1'b0;
      end else if (!in_job && req_valid && !rst) begin
        acc_cyc  = cyc;
        legal    = (req_op == 2'b01) || (req_op == 2'b10);
        lat_op   = req_op; lat_d = req_data; lat_k = req_key;
        n_clr    = 0; n_bgn = 0; rv_seen = 1'b0; last_bgn = -1000;
        if (!legal) begin
          rs = cyc + 1; e_err = 2'b01; e_d = '0; e_k = '0;
        end else begin
          lb  = cyc + CLR + BGN;        // last cycle of core_bgn
          lim = cyc + CLR + 1 + TMO;    // cycle in which the timeout counter reads TMO
          mx  = (cfg_dd > cfg_dk) ? cfg_dd : cfg_dk;
          if (cfg_dd >= 0 && cfg_dk >= 0 && lb + mx <= lim) begin
            rs = lb + mx + 1; e_err = 2'b00;
          end else begin
            rs = lim + 1; e_err = 2'b10;
          end
          e_d = (cfg_dd >= 0 && lb + cfg_dd <= lim) ? 16'hA1B2 : 16'h0000;
          e_k = (cfg_dk >= 0 && lb + cfg_dk <= lim) ? 16'hC3D4 : 16'h0000;
        end
        in_job = 1'b1;
      end
    end
    if (end_req || cyc > 20000) begin
      if (!end_req) chk("run watchdog", 32'(cyc), 32'(0));
      chk("stimulus waits expired", 32'(stim_timeouts), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  task automatic await_accept();
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) stim_timeouts++;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [15:0] k);
    @(posedge clk); #1;
    req_op = op; req_data = d; req_key = k; req_valid = 1'b1;
    await_accept();
  endtask

  task automatic wait_rv();
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #1;
      got = rv_seen;
    end
    if (!got) stim_timeouts++;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = !busy;
    end
    if (!got) stim_timeouts++;
  endtask

  task automatic set_pins(input int rel, input int c, input int b,
                          input logic [15:0] d, input logic [15:0] k, input int e);
    pin_on = 1'b1; pin_rel = rel; pin_clr = c; pin_bgn = b; pin_d = d; pin_k = k; pin_e = e;
  endtask

  task automatic run_job(input logic [1:0] op, input logic [15:0] d, input logic [15:0] k,
                         input int dd, input int dk, input bit stray,
                         input int rel, input int c, input int b,
                         input logic [15:0] pd, input logic [15:0] pk, input int pe);
    cfg_dd = dd; cfg_dk = dk; cfg_stray = stray;
    set_pins(rel, c, b, pd, pk, pe);
    send(op, d, k);
    wait_rv();
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_data = '0; req_key = '0; resp_ready = 1'b1;
    cfg_dd = -1; cfg_dk = -1; cfg_stray = 1'b0; pin_on = 1'b0; end_req = 1'b0; stim_timeouts = 0;
    pin_rel = 0; pin_clr = 0; pin_bgn = 0; pin_d = '0; pin_k = '0; pin_e = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // encrypt, both strobes 30 cycles after last begin
    run_job(2'b01, 16'h59B3, 16'h1325, 30, 30, 1'b0, 43, 2, 10, 16'hA1B2, 16'hC3D4, 0);
    // decrypt, data at +20, key at +21
    run_job(2'b10, 16'h36CB, 16'hA058, 20, 21, 1'b0, 34, 2, 10, 16'hA1B2, 16'hC3D4, 0);
    // illegal ops never touch the core
    run_job(2'b11, 16'hABCD, 16'h1234, 30, 30, 1'b0, 1, 0, 0, 16'h0000, 16'h0000, 1);
    run_job(2'b00, 16'h4321, 16'h8765, 30, 30, 1'b0, 1, 0, 0, 16'h0000, 16'h0000, 1);
    // timeout with no strobes, then with data only (stray strobes in CLEAR ignored)
    run_job(2'b01, 16'h1111, 16'h2222, -1, -1, 1'b0, 259, 2, 10, 16'h0000, 16'h0000, 2);
    run_job(2'b10, 16'h3333, 16'h4444, 30, -1, 1'b1, 259, 2, 10, 16'hA1B2, 16'h0000, 2);
    cfg_stray = 1'b0;

    // response stalled 5 cycles while the next request is already waiting
    @(posedge clk); #1 resp_ready = 1'b0;
    cfg_dd = 30; cfg_dk = 30;
    set_pins(43, 2, 10, 16'hA1B2, 16'hC3D4, 0);
    send(2'b01, 16'h1234, 16'h5678);
    wait_rv();
    @(posedge clk); #1;
    cfg_dd = 5; cfg_dk = 7;
    set_pins(20, 2, 10, 16'hA1B2, 16'hC3D4, 0);
    req_op = 2'b10; req_data = 16'h0F0F; req_key = 16'hF0F0; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1 resp_ready = 1'b1;
    await_accept();
    wait_rv();
    wait_idle();

    // reset pulse in WAIT aborts the job, then a normal encrypt
    cfg_dd = -1; cfg_dk = -1; pin_on = 1'b0;
    send(2'b01, 16'hCAFE, 16'hBEEF);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    run_job(2'b01, 16'h59B3, 16'h1325, 30, 30, 1'b0, 43, 2, 10, 16'hA1B2, 16'hC3D4, 0);

    repeat (5) @(posedge clk);
    #1 end_req = 1'b1;
  end

endmodule
